// File: rtl/draw_pkg.sv
// Shared types and default geometry for the maze cell box drawing engine.
// Optional outline scanning is enabled by defining DRAW_CELL_BOX_OUTLINE_EN.
package draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    localparam int DEF_CELL_W     = 10;
    localparam int DEF_BOX_W      = 9;
    localparam int DEF_X_OFFSET   = 80;
    localparam int DEF_Y_OFFSET   = 0;
    localparam int DEF_GRID_BITS  = 5;
    localparam int DEF_COORD_BITS = 9;
    localparam int DEF_COLOR_BITS = 3;
    localparam int DEF_BG_COLOR   = 0;

    // Counter width for a box side; a single-pixel box still needs one bit.
    function automatic int cnt_width(input int box_w);
        return (box_w > 1) ? $clog2(box_w) : 1;
    endfunction

endpackage

// File: rtl/box_scan_counter.sv
// Raster cx/cy counter over a BOX_W x BOX_W square with a last-pixel flag.
// With DRAW_CELL_BOX_OUTLINE_EN defined, interior rows can skip from cx=0 to cx=BOX_W-1.
module box_scan_counter
    import draw_pkg::*;
#(
    parameter int BOX_W = DEF_BOX_W,
    parameter int CNT_W = cnt_width(BOX_W)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clear,
    input  logic             i_advance,
`ifdef DRAW_CELL_BOX_OUTLINE_EN
    input  logic             i_outline,
`endif
    output logic [CNT_W-1:0] o_next_cx,
    output logic [CNT_W-1:0] o_next_cy,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BOX_W - 1);

    logic [CNT_W-1:0] r_cx;
    logic [CNT_W-1:0] r_cy;
    logic [CNT_W-1:0] w_nx;
    logic [CNT_W-1:0] w_ny;

`ifdef DRAW_CELL_BOX_OUTLINE_EN
    logic w_row_edge;
    assign w_row_edge = (r_cy == '0) || (r_cy == LAST);
`endif

    always_comb begin
        w_nx = r_cx;
        w_ny = r_cy;
        if (r_cx == LAST) begin
            w_nx = '0;
            w_ny = r_cy + 1'b1;
        end
`ifdef DRAW_CELL_BOX_OUTLINE_EN
        else if (i_outline && !w_row_edge && (r_cx == '0)) begin
            w_nx = LAST;
        end
`endif
        else begin
            w_nx = r_cx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_clear) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_advance) begin
            r_cx <= w_nx;
            r_cy <= w_ny;
        end
    end

    assign o_next_cx = w_nx;
    assign o_next_cy = w_ny;
    assign o_last    = (r_cx == LAST) && (r_cy == LAST);

endmodule

// File: rtl/draw_cell_box.sv
// Streams one pixel per clock over a maze cell's square, then pulses done.
// Outline-only scanning is built in only when DRAW_CELL_BOX_OUTLINE_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   DRAW  | one pixel presented per cycle
//   DONE  | done pulse, busy still high
module draw_cell_box
    import draw_pkg::*;
#(
    parameter int CELL_W     = DEF_CELL_W,
    parameter int BOX_W      = DEF_BOX_W,
    parameter int X_OFFSET   = DEF_X_OFFSET,
    parameter int Y_OFFSET   = DEF_Y_OFFSET,
    parameter int GRID_BITS  = DEF_GRID_BITS,
    parameter int COORD_BITS = DEF_COORD_BITS,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int BG_COLOR   = DEF_BG_COLOR
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  erase,
    input  logic                  outline,
    input  logic [GRID_BITS-1:0]  x_cell,
    input  logic [GRID_BITS-1:0]  y_cell,
    input  logic [COLOR_BITS-1:0] color_in,
    output logic                  busy,
    output logic                  plot,
    output logic [COORD_BITS-1:0] x_pix,
    output logic [COORD_BITS-1:0] y_pix,
    output logic [COLOR_BITS-1:0] color_out,
    output logic                  done
);

    localparam int CNT_W = cnt_width(BOX_W);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_DRAW = 2'(ST_DRAW);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]            r_state;
    logic [COORD_BITS-1:0] r_base_x;
    logic [COORD_BITS-1:0] r_base_y;
    logic [COLOR_BITS-1:0] r_fill_color;
    logic                  r_busy;
    logic                  r_plot;
    logic                  r_done;
    logic [COORD_BITS-1:0] r_x;
    logic [COORD_BITS-1:0] r_y;
    logic [COLOR_BITS-1:0] r_color;

    logic [COORD_BITS-1:0] w_base_x_in;
    logic [COORD_BITS-1:0] w_base_y_in;
    logic [COLOR_BITS-1:0] w_color_in;
    logic [CNT_W-1:0]      w_nx;
    logic [CNT_W-1:0]      w_ny;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_advance;

    // Cell origin wraps modulo 2^COORD_BITS; the integrator keeps it on screen.
    assign w_base_x_in = COORD_BITS'(X_OFFSET) + COORD_BITS'(x_cell) * COORD_BITS'(CELL_W);
    assign w_base_y_in = COORD_BITS'(Y_OFFSET) + COORD_BITS'(y_cell) * COORD_BITS'(CELL_W);
    assign w_color_in  = erase ? COLOR_BITS'(BG_COLOR) : color_in;

    assign w_clear   = (r_state == S_IDLE);
    assign w_advance = (r_state == S_DRAW) && !w_last;

`ifdef DRAW_CELL_BOX_OUTLINE_EN
    logic r_outline;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outline <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_outline <= outline;
        end
    end

    box_scan_counter #(
        .BOX_W (BOX_W),
        .CNT_W (CNT_W)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_outline (r_outline),
        .o_next_cx (w_nx),
        .o_next_cy (w_ny),
        .o_last    (w_last)
    );
`else
    logic w_unused_outline;
    assign w_unused_outline = outline;

    box_scan_counter #(
        .BOX_W (BOX_W),
        .CNT_W (CNT_W)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_next_cx (w_nx),
        .o_next_cy (w_ny),
        .o_last    (w_last)
    );
`endif

    // Output registers hold the pixel the counter currently points at.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_base_x     <= '0;
            r_base_y     <= '0;
            r_fill_color <= '0;
            r_busy       <= 1'b0;
            r_plot       <= 1'b0;
            r_done       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_color      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state      <= S_DRAW;
                        r_base_x     <= w_base_x_in;
                        r_base_y     <= w_base_y_in;
                        r_fill_color <= w_color_in;
                        r_busy       <= 1'b1;
                        r_plot       <= 1'b1;
                        r_x          <= w_base_x_in;
                        r_y          <= w_base_y_in;
                        r_color      <= w_color_in;
                    end
                end
                S_DRAW: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_plot  <= 1'b0;
                        r_done  <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_color <= '0;
                    end else begin
                        r_x     <= r_base_x + COORD_BITS'(w_nx);
                        r_y     <= r_base_y + COORD_BITS'(w_ny);
                        r_color <= r_fill_color;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                    r_done  <= 1'b0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_color <= '0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign plot      = r_plot;
    assign done      = r_done;
    assign x_pix     = r_x;
    assign y_pix     = r_y;
    assign color_out = r_color;

endmodule

// File: doc/draw_cell_box.md
# draw_cell_box

Parametrised pixel-box drawing engine for the maze VGA path: on a start pulse it latches a maze cell coordinate and streams one pixel per clock covering that cell's square to the framebuffer/VGA adapter, then pulses done. It generalises the old-box eraser with parametrised cell geometry, screen offset and colour width, a fill-or-erase mode, a clean start/busy/done handshake, and an optional outline-only scan. It sits between the player/maze control FSM and the VGA adapter write port.

## Interface
- CELL_W, 10, cell pitch in pixels
- BOX_W, 9, drawn box side in pixels (1 ≤ BOX_W ≤ CELL_W)
- X_OFFSET, 80, screen x of cell (0,0)
- Y_OFFSET, 0, screen y of cell (0,0)
- GRID_BITS, 5, width of cell coordinates
- COORD_BITS, 9, width of pixel coordinates
- COLOR_BITS, 3, colour width
- BG_COLOR, 0, colour used for erase
- clk  in  1  system clock, rising edge
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  request pulse; accepted only when busy=0
- erase  in  1  1: draw BG_COLOR; 0: draw color_in (latched at start)
- outline  in  1  1: perimeter only (effective only with macro; else ignored)
- x_cell, y_cell  in  GRID_BITS  cell coordinates (latched at start)
- color_in  in  COLOR_BITS  fill colour (latched at start)
- busy  out  1  high from cycle after accepted start through done cycle
- plot  out  1  pixel write strobe
- x_pix, y_pix  out  COORD_BITS  pixel coordinate, valid when plot=1
- color_out  out  COLOR_BITS  pixel colour, valid when plot=1
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: start=1 → latch x_cell, y_cell, erase?BG_COLOR:color_in, outline; cx=cy=0; go DRAW.
- DRAW: each cycle plot=1, x_pix=X_OFFSET+x_cell*CELL_W+cx, y_pix=Y_OFFSET+y_cell*CELL_W+cy; cx increments, at BOX_W-1 wraps to 0 and cy increments; raster order, row-major.
- Last pixel (cx=cy=BOX_W-1) → DONE. DONE: done=1, plot=0, → IDLE.
- plot=0 ⇒ x_pix, y_pix, color_out driven 0.
- start during DRAW/DONE ignored (not queued); input changes after acceptance have no effect.
- Arithmetic in COORD_BITS, modulo 2^COORD_BITS; integrator guarantees in-range coordinates, no clamping.
- Reset (any state): IDLE, cx=cy=0, busy=plot=done=0, x_pix=y_pix=color_out=0; interrupted box is abandoned, no done.

## Timing
- start sampled at edge 0 → first plot at cycle 1, last plot at cycle N, done at cycle N+1, busy low at N+2; new start accepted from cycle N+2.
- N = BOX_W² (fill) or perimeter count (outline).
- Outputs registered; no combinational input→output path.
- BOX_W=1: single pixel, done at cycle 2.

## Configuration
- DRAW_CELL_BOX_OUTLINE_EN defined: outline=1 scans rows 0 and BOX_W-1 fully; other rows emit cx=0 then jump to cx=BOX_W-1; N=4·(BOX_W-1) for BOX_W≥2, 1 for BOX_W=1.
- Undefined: outline ignored, always full fill; no skip logic synthesised.

## Structure
- Shared package draw_pkg: state enum (IDLE/DRAW/DONE), default geometry constants (CELL_W, BOX_W, X_OFFSET, COLOR_BITS), BG_COLOR.
- One sub-module: box_scan_counter (cx/cy counter with last flag and outline skip).

## Test plan
- Defaults, start with x_cell=2, y_cell=3, erase=1 → 81 plots, first (100,30), last (108,38), color_out=0, done at cycle 82.
- erase=0, color_in=3'b101, cell (0,0) → 81 plots colour 5, x 80..88, y 0..8, raster order.
- start repulsed every cycle during DRAW → exactly one box drawn, single done, following start accepted at cycle 83.
- resetn low at cycle 40 → all outputs 0 immediately, no done; next start draws full box from (cx,cy)=(0,0).
- Macro defined, outline=1, BOX_W=9 → 32 plots, none with 0<cx<8 and 0<cy<8, done at cycle 33.
- BOX_W=1, cell (31,31) → single plot at (80+310, 310) mod 512 = (390,310), done at cycle 2.
